// File: rtl/mem_responder.sv
// Memory-side responder: synchronous-read RAM plus a 16-word MMIO page (LEDs,
// switches, timer, char FIFO).
module mem_responder #(
  parameter int          RAM_WORDS = 16384,
  parameter logic [14:0] MMIO_BASE = 15'h7FF0,
  parameter int          TIMER_DIV = 1,
  parameter string       INIT_FILE = "program.hex"
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [14:0] memory_addr,
  input  logic [15:0] data_in,
  input  logic        write,
  output logic [15:0] data_out,
  input  logic [7:0]  switches,
  output logic [7:0]  leds,
  output logic [7:0]  char_data,
  output logic        char_valid,
  input  logic        char_ready
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

  // ---------------- decode ----------------
  // MMIO page is assumed 16-word aligned; RAM wins if the two ever overlap.
  logic       in_ram, in_page;
  logic [3:0] reg_idx;

  assign in_ram  = (32'(memory_addr) < RAM_WORDS);
  assign in_page = !in_ram && (memory_addr[14:4] == MMIO_BASE[14:4]);
  assign reg_idx = memory_addr[3:0];

  logic led_we, tmr_we, fifo_acc, push_req;
  assign led_we   = write && in_page && (reg_idx == 4'd0);
  assign tmr_we   = write && in_page && (reg_idx == 4'd2);
  assign fifo_acc = in_page && (reg_idx == 4'd3);
  assign push_req = write && fifo_acc;

  // ---------------- RAM ----------------
  logic [15:0] ram [RAM_WORDS];
  logic [15:0] ram_q;
  logic        ram_we;

  assign ram_we = write && in_ram && !reset;

  // Read-before-write: ram_q captures the pre-write contents.
  always_ff @(posedge clk) begin
    if (ram_we) ram[memory_addr[AW-1:0]] <= data_in;
    ram_q <= ram[memory_addr[AW-1:0]];
  end

  // ---------------- MMIO registers ----------------
  logic [7:0]    sw_meta, sw_sync;
  logic [15:0]   timer;
  logic [PW-1:0] prescaler;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      leds      <= '0;
      sw_meta   <= '0;
      sw_sync   <= '0;
      timer     <= '0;
      prescaler <= '0;
    end else begin
      sw_meta <= switches;
      sw_sync <= sw_meta;
      if (led_we) leds <= data_in[7:0];
      if (tmr_we) begin
        timer     <= '0;
        prescaler <= '0;
      end else if (prescaler == PW'(TIMER_DIV - 1)) begin
        timer     <= timer + 16'd1;
        prescaler <= '0;
      end else begin
        prescaler <= prescaler + PW'(1);
      end
    end
  end

  // ---------------- char FIFO ----------------
  logic [3:0][7:0] fifo_mem;
  logic [1:0]      rd_ptr, wr_ptr;
  logic [2:0]      count;
  logic            full, empty, overflow, pop, push;

  assign full       = (count == 3'd4);
  assign empty      = (count == 3'd0);
  assign char_valid = !empty;
  assign char_data  = char_valid ? fifo_mem[rd_ptr] : 8'h00;
  assign pop        = char_valid && char_ready;
  assign push       = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= data_in[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      // A dropped push must stay visible even though that access also reads status.
      if (push_req && full && !pop) overflow <= 1'b1;
      else if (fifo_acc)            overflow <= 1'b0;
    end
  end

  // ---------------- read path ----------------
  logic [15:0] mmio_rd, mmio_q;
  logic        sel_ram;

  always_comb begin
    mmio_rd = '0;
    if (in_page) begin
      case (reg_idx)
        4'd0:    mmio_rd = {8'h00, leds};
        4'd1:    mmio_rd = {8'h00, sw_sync};
        4'd2:    mmio_rd = timer;
        4'd3:    mmio_rd = {13'b0, overflow, full, empty};
        default: mmio_rd = '0;
      endcase
    end
  end

  // RAM output stays unreset; the select flop forces data_out to 0 in reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_ram <= 1'b0;
      mmio_q  <= '0;
    end else begin
      sel_ram <= in_ram;
      mmio_q  <= mmio_rd;
    end
  end

  assign data_out = sel_ram ? ram_q : mmio_q;

endmodule
